small_encode_pack: RTL and testbench

//  Downstream of the mod-3 reduction datapath. Consumes one residue per coefficient (0..2) of a

---
 rtl/sntrup_pkg.sv | 22 ++
 rtl/small_encode_pack_if.sv | 24 ++
 rtl/small_encode_pack.sv | 127 ++++++++++++
 tb/tb_small_encode_pack.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sntrup_pkg.sv
// Shared constants, state encoding and residue-to-code map for the SNTRUP757 small-poly packer.
package sntrup_pkg;

  localparam int unsigned P      = 757;
  localparam int unsigned W      = 13;
  localparam int unsigned NBYTES = (P + 3) / 4;
  localparam int unsigned CoefW  = $clog2(P);
  localparam int unsigned ByteW  = $clog2(NBYTES);

  typedef enum logic [1:0] {StIdle, StPack, StDrain, StDone} state_e;

  // Centered f in {-1,0,1} stored as f+1; out-of-range residues fall back to f=0.
  function automatic logic [1:0] small_code(input logic [W-1:0] m);
    case (m)
      W'(0):   small_code = 2'b01;
      W'(1):   small_code = 2'b10;
      W'(2):   small_code = 2'b00;
      default: small_code = 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/small_encode_pack_if.sv
// Residue input stream and packed byte output stream of small_encode_pack.
interface small_encode_pack_if #(
  parameter int unsigned Width = 13
);

  logic [Width-1:0] in_mod;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_mod, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_last
  );

  modport slave (
    input  in_mod, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_last
  );

endinterface

// File: rtl/small_encode_pack.sv
// Packs P mod-3 residues into the Small_encode byte stream, 4 two-bit codes per byte, LSB first.
module small_encode_pack
  import sntrup_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  small_encode_pack_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e           state_q, state_d;
  logic [CoefW-1:0] coef_q, coef_d;
  logic [1:0]       slot_q, slot_d;
  logic [7:0]       acc_q, acc_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [7:0]       obyte_q, obyte_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;
  logic             err_q, err_d;

  logic             accept;
  logic             out_hs;
  logic             last_coef;
  logic [7:0]       acc_ins;

  assign bus.in_ready  = (state_q == StPack) && (!ovalid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_hs        = ovalid_q && bus.out_ready;
  assign last_coef     = (coef_q == CoefW'(P - 1));

  assign bus.out_byte  = obyte_q;
  assign bus.out_valid = ovalid_q;
  assign bus.out_last  = olast_q;
  assign busy          = (state_q == StPack) || (state_q == StDrain);
  assign done          = (state_q == StDone);
  assign err           = err_q;

  always_comb begin
    acc_ins = acc_q;
    acc_ins[{slot_q, 1'b0} +: 2] = small_code(bus.in_mod);
  end

  always_comb begin
    state_d  = state_q;
    coef_d   = coef_q;
    slot_d   = slot_q;
    acc_d    = acc_q;
    byte_d   = byte_q;
    obyte_d  = obyte_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPack;
          coef_d  = '0;
          slot_d  = '0;
          acc_d   = '0;
          byte_d  = '0;
          err_d   = 1'b0;
        end
      end
      StPack: begin
        if (out_hs) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
        end
        if (accept) begin
          if (bus.in_mod > W'(2)) err_d = 1'b1;
          // A new byte may load on the same edge the previous one is consumed.
          if (slot_q == 2'd3 || last_coef) begin
            obyte_d  = acc_ins;
            ovalid_d = 1'b1;
            olast_d  = (byte_q == ByteW'(NBYTES - 1));
            acc_d    = '0;
            slot_d   = '0;
            if (byte_q != ByteW'(NBYTES - 1)) byte_d = byte_q + 1'b1;
          end else begin
            acc_d  = acc_ins;
            slot_d = slot_q + 1'b1;
          end
          if (last_coef) state_d = StDrain;
          else           coef_d  = coef_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_hs) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      coef_q   <= '0;
      slot_q   <= '0;
      acc_q    <= '0;
      byte_q   <= '0;
      obyte_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      coef_q   <= coef_d;
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      byte_q   <= byte_d;
      obyte_q  <= obyte_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_small_encode_pack.sv
// Directed bench for small_encode_pack: full-polynomial runs checked byte by byte against a model.
module tb_small_encode_pack;
  import sntrup_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  small_encode_pack_if #(.Width(W)) ifc ();

  small_encode_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (ifc.slave),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc;
  int done_cycles;
  logic [7:0] got[$];
  logic       lastf[$];
  int unsigned pat1 [12] = '{1, 2, 0, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic int res_of(input int mode, input int i);
    if (mode == 1) return (i < 12) ? int'(pat1[i]) : 0;
    if (mode == 2) return (i == 5) ? 3 : (i % 3);
    return 0;
  endfunction

  function automatic logic [1:0] tb_code(input int r);
    case (r)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int mode, input int k);
    logic [7:0] b = 8'h00;
    for (int s = 0; s < 4; s++) begin
      if (4 * k + s < int'(P)) b = b | (8'(tb_code(res_of(mode, 4 * k + s))) << (2 * s));
    end
    return b;
  endfunction

  // Sample the current cycle's handshakes, then advance to just after the next rising edge.
  task automatic tick();
    if (ifc.out_valid && ifc.out_ready) begin
      got.push_back(ifc.out_byte);
      lastf.push_back(ifc.out_last);
    end
    if (ifc.in_valid && ifc.in_ready) n_acc++;
    if (done) done_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_poly(input int mode, input bit stall, input bit hold_start,
                          input int abort_at);
    int stall_left = 0;
    bit stall_done = 1'b0;
    logic [7:0] held = 8'h00;
    int cyc = 0;
    got.delete();
    lastf.delete();
    n_acc = 0;
    done_cycles = 0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = hold_start;
    chk("busy_after_start", mode, 32'(busy), 32'd1);
    chk("err_clear_on_start", mode, 32'(err), 32'd0);
    while (cyc < 5000) begin
      if (abort_at >= 0 && n_acc == abort_at) break;
      ifc.in_valid = (n_acc < int'(P));
      ifc.in_mod   = W'(res_of(mode, n_acc));
      if (stall && !stall_done && ifc.out_valid) begin
        stall_left = 10;
        stall_done = 1'b1;
        held = ifc.out_byte;
      end
      ifc.out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", stall_left, 32'(ifc.in_ready), 32'd0);
        chk("stall_hold", stall_left, 32'(ifc.out_byte), 32'(held));
        chk("stall_valid", stall_left, 32'(ifc.out_valid), 32'd1);
        stall_left--;
      end
      if (mode == 2 && n_acc == 5) chk("err_before", n_acc, 32'(err), 32'd0);
      if (mode == 2 && n_acc == 6) chk("err_after", n_acc, 32'(err), 32'd1);
      if (done) begin
        chk("done_not_busy", mode, 32'(busy), 32'd0);
        chk("done_in_ready", mode, 32'(ifc.in_ready), 32'd0);
      end
      tick();
      cyc++;
      if (done_cycles > 0) break;
    end
    ifc.in_valid = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) return;
    chk("done_pulses", mode, 32'(done_cycles), 32'd1);
    chk("done_one_cycle", mode, 32'(done), 32'd0);
    chk("idle_busy", mode, 32'(busy), 32'd0);
    chk("byte_count", mode, 32'(got.size()), NBYTES);
    for (int k = 0; k < got.size() && k < int'(NBYTES); k++) begin
      chk("byte", k, 32'(got[k]), 32'(exp_byte(mode, k)));
      chk("last", k, 32'(lastf[k]), 32'(k == int'(NBYTES) - 1));
    end
  endtask

  initial begin
    ifc.in_mod    = '0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(ifc.out_valid), 32'd0);
    chk("rst_out_byte", 0, 32'(ifc.out_byte), 32'd0);
    chk("rst_out_last", 0, 32'(ifc.out_last), 32'd0);
    chk("rst_in_ready", 0, 32'(ifc.in_ready), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_done", 0, 32'(done), 32'd0);
    chk("rst_err", 0, 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero residues.
    run_poly(0, 1'b0, 1'b0, -1);
    if (got.size() == int'(NBYTES)) begin
      chk("zero_first", 0, 32'(got[0]), 32'h55);
      chk("zero_final", 189, 32'(got[189]), 32'h01);
    end else chk("zero_size", 0, 32'(got.size()), NBYTES);

    // Leading pattern 1,2,0,1 / 2,2,2,2 / 1,1,1,1.
    run_poly(1, 1'b0, 1'b0, -1);
    if (got.size() >= 3) begin
      chk("pat_b0", 0, 32'(got[0]), 32'h92);
      chk("pat_b1", 1, 32'(got[1]), 32'h00);
      chk("pat_b2", 2, 32'(got[2]), 32'hAA);
    end else chk("pat_size", 0, 32'(got.size()), NBYTES);

    // Consumer stalls for 10 cycles after the first byte.
    run_poly(0, 1'b1, 1'b0, -1);

    // Illegal residue 3 at coef 5; err must persist until the next start.
    run_poly(2, 1'b0, 1'b0, -1);
    if (got.size() >= 2) chk("err_b1", 1, 32'(got[1]), 32'h96);
    chk("err_sticky", 0, 32'(err), 32'd1);

    // start held high through PACK and DRAIN.
    run_poly(1, 1'b0, 1'b1, -1);

    // Asynchronous reset mid-polynomial, then a clean run.
    run_poly(2, 1'b0, 1'b0, 400);
    chk("abort_err_set", 0, 32'(err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(busy), 32'd0);
    chk("abort_out_valid", 0, 32'(ifc.out_valid), 32'd0);
    chk("abort_in_ready", 0, 32'(ifc.in_ready), 32'd0);
    chk("abort_err", 0, 32'(err), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    done_cycles = 0;
    repeat (5) tick();
    chk("abort_no_done", 0, 32'(done_cycles), 32'd0);
    run_poly(0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
